rtc_field_editor: RTL and testbench
===================================

// Module: rtc_field_editor
// PURPOSE
//  Parametrised editor for one BCD field of the RTC (day, month, year, hour, minute, second).
//  - Detects UP/DOWN button presses and steps the current BCD value by ±1 with range wrap.
//  - Optionally applies the day-of-month limit (28/29/30/31).
//  - Writes the result to the RTC bus as an address phase followed by a data phase, with a req/ack handshake.
//  - Sits between the button debouncers and the RTC bus controller; one instance per field.
// PARAMETERS
//  FIELD_ADDR  8'h24  RTC register address driven in the address phase
//  MIN_VAL     8'h01  lowest legal BCD value of the field
//  MAX_VAL     8'h31  highest legal BCD value (used when DOM_MODE=0, or as ceiling when DOM_MODE=1)
//  DOM_MODE    0      1: max = days-in-month derived from month_bcd/year_bcd; 0: fixed MAX_VAL
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-low reset
//  enable     in   1  field selected for editing; low forces IDLE at next edge
//  up         in   1  debounced increment button (level)
//  down       in   1  debounced decrement button (level)
//  value_in   in   8  current BCD field value read from RTC
//  month_bcd  in   8  current month BCD (DOM_MODE=1 only)
//  year_bcd   in   8  current 2-digit year BCD (DOM_MODE=1 only)
//  bus_ack    in   1  bus controller has completed current phase (1-cycle pulse)
//  bus_req    out  1  request for current bus phase
//  a_d        out  1  0 = address phase, 1 = data phase
//  w_r        out  1  1 = write
//  bus_data   out  8  address (addr phase) or new BCD value (data phase)
//  busy       out  1  transaction in progress (CALC..DATA)
//  done       out  1  1-cycle pulse after data phase acked
//  value_out  out  8  registered new value, held until next transaction
// BEHAVIOUR
//  - Reset (reset==0 at posedge clk): state=IDLE; all outputs 0; edge-detect history regs 0.
//  - Press detection: up_p = up & ~up_q, down_p = down & ~down_q, using registered history.
//    - Only up_p XOR down_p starts a transaction.
//    - Both pulses in the same cycle: ignored, no write.
//  - FSM:
//    - IDLE -> CALC on valid press while enable=1.
//    - CALC (1 cycle): latch value_out = step(value_in). -> ADDR.
//    - ADDR: bus_req=1, a_d=0, w_r=1, bus_data=FIELD_ADDR; hold until bus_ack. -> DATA.
//    - DATA: bus_req=1, a_d=1, w_r=1, bus_data=value_out; hold until bus_ack. -> DONE.
//    - DONE: done=1 for one cycle, bus_req=0. -> IDLE.
//  - Latency: press edge -> first bus_req is 2 cycles, when bus_ack returns immediately.
//  - Presses arriving while busy are dropped; history regs still update, so no late trigger.
//  - step(): BCD ±1 on 8 bits; the units digit rolls 9->0 with a tens carry, and 0->9 with a tens borrow.
//    - up at max -> MIN_VAL.
//    - down at MIN_VAL -> max.
//  - Out-of-range input (value_in < MIN_VAL, value_in > max, or any nibble > 9):
//    - up -> MIN_VAL.
//    - down -> max.
//  - DOM_MODE=1 max:
//    - month 02 -> 29 if leap, else 28.
//    - months 04/06/09/11 -> 30.
//    - all others -> 31; result capped at MAX_VAL.
//    - Leap: tens even & units in {0,4,8}, or tens odd & units in {2,6}.
//  - month_bcd/year_bcd are sampled in CALC only.
//  - enable=0 or reset mid-transaction: abort to IDLE next edge, bus_req=0, no done pulse.
//    - value_out retains its last committed value (reset clears it to 0).
//  - bus_ack outside ADDR/DATA is ignored.
// STRUCTURE
//  - rtc_defs.vh: state encodings (IDLE, CALC, ADDR, DATA, DONE; 3 bits), RTC register address constants, BCD_MAX_DIGIT.
//  - Sub-module bcd_step: combinational; inputs val, dir, min, max; output next. Instantiated once.
//  - Top holds edge detect, days-in-month logic, FSM, and output registers (all outputs registered).
// TESTING
//  - DOM_MODE=1, value_in=8'h31, month=8'h12, up press -> ADDR bus_data=8'h24, DATA bus_data=8'h01, done pulse.
//  - DOM_MODE=1, value_in=8'h01, month=8'h02, year=8'h24, down -> 8'h29; same with year=8'h23 -> 8'h28.
//  - DOM_MODE=0, MIN=8'h00, MAX=8'h59, value_in=8'h09, up -> 8'h10; value_in=8'h00, down -> 8'h59.
//  - up and down rise in the same cycle; also up held for 20 cycles -> one transaction or none, never repeats.
//  - bus_ack withheld 10 cycles in ADDR, then enable dropped -> IDLE, bus_req=0, no done.
//  - reset asserted in DATA -> all outputs 0 next edge; value_in=8'h35 (>max 31), up -> 8'h01.

Source files
------------

// File: rtl/rtc_field_editor_pkg.sv
// rtl/rtc_field_editor_pkg.sv - shared types, constants and days-in-month helper for the RTC field editor
//
// Purpose: FSM state encoding, RTC register addresses, BCD digit limit and the
//          days-in-month lookup used when a field is a day-of-month.
package rtc_field_editor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] RTC_ADDR_MIN  = 8'h21;
    localparam logic [7:0] RTC_ADDR_DAY  = 8'h24;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Two-digit BCD year is a leap year when its value is a multiple of 4:
    // even tens need units 0/4/8, odd tens need units 2/6.
    function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                                 input logic [7:0] year_bcd);
        logic leap;
        leap = year_bcd[4] ? ((year_bcd[3:0] == 4'd2) || (year_bcd[3:0] == 4'd6))
                           : ((year_bcd[3:0] == 4'd0) || (year_bcd[3:0] == 4'd4) ||
                              (year_bcd[3:0] == 4'd8));
        case (month_bcd)
            8'h02:                      days_in_month = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
            default:                    days_in_month = 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_field_editor_bcd_step.sv
// rtl/rtc_field_editor_bcd_step.sv - combinational BCD +/-1 with range wrap
//
// Purpose: steps a two-digit BCD value up or down by one inside [min_i, max_i].
// Ports:
//   val_i  [7:0]  current BCD value
//   dir_i         1 = increment, 0 = decrement
//   min_i  [7:0]  lowest legal BCD value
//   max_i  [7:0]  highest legal BCD value
//   next_o [7:0]  stepped BCD value
module rtc_field_editor_bcd_step
    import rtc_field_editor_pkg::*;
(
    input  logic [7:0] val_i,
    input  logic       dir_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    output logic [7:0] next_o
);

    logic [3:0] tens;
    logic [3:0] units;
    logic       in_range;

    assign tens  = val_i[7:4];
    assign units = val_i[3:0];

    // Valid BCD orders the same as plain binary, so range checks compare bytes.
    assign in_range = (tens <= BCD_MAX_DIGIT) && (units <= BCD_MAX_DIGIT) &&
                      (val_i >= min_i) && (val_i <= max_i);

    always_comb begin
        next_o = min_i;
        if (dir_i) begin
            if (!in_range || (val_i == max_i)) begin
                next_o = min_i;
            end else if (units == BCD_MAX_DIGIT) begin
                next_o = {tens + 4'd1, 4'd0};
            end else begin
                next_o = {tens, units + 4'd1};
            end
        end else begin
            if (!in_range || (val_i == min_i)) begin
                next_o = max_i;
            end else if (units == 4'd0) begin
                next_o = {tens - 4'd1, BCD_MAX_DIGIT};
            end else begin
                next_o = {tens, units - 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_field_editor.sv
// rtl/rtc_field_editor.sv - one-field RTC editor: button step, then address/data write on the RTC bus
//
// Purpose: on a single UP or DOWN press, steps the field's BCD value and writes
//          it to the RTC as an address phase followed by a data phase.
// Ports:
//   clk_i, reset_i          clock, synchronous active-low reset
//   enable_i                field selected; low aborts to idle
//   up_i, down_i            debounced button levels
//   value_in_i [7:0]        current BCD field value
//   month_bcd_i, year_bcd_i day-of-month limit inputs (DOM_MODE=1)
//   bus_ack_i               bus phase complete pulse
//   bus_req_o, a_d_o, w_r_o, bus_data_o [7:0]  bus phase outputs
//   busy_o, done_o          transaction in progress / finished pulse
//   value_out_o [7:0]       last computed value
module rtc_field_editor
    import rtc_field_editor_pkg::*;
#(
    parameter logic [7:0] FIELD_ADDR = RTC_ADDR_DAY,
    parameter logic [7:0] MIN_VAL    = 8'h01,
    parameter logic [7:0] MAX_VAL    = 8'h31,
    parameter bit         DOM_MODE   = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic [7:0] value_in_i,
    input  logic [7:0] month_bcd_i,
    input  logic [7:0] year_bcd_i,
    input  logic       bus_ack_i,
    output logic       bus_req_o,
    output logic       a_d_o,
    output logic       w_r_o,
    output logic [7:0] bus_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] value_out_o
);

    state_t     state_q;
    logic       up_q, down_q;
    logic       dir_q;
    logic       bus_req_q, a_d_q, w_r_q, busy_q, done_q;
    logic [7:0] bus_data_q, value_out_q;

    logic       up_p, down_p;
    logic [7:0] dim;
    logic [7:0] max_val;
    logic [7:0] value_d;

    assign up_p   = up_i & ~up_q;
    assign down_p = down_i & ~down_q;

    // Only consumed in CALC, so month/year are effectively sampled there.
    always_comb begin
        dim     = days_in_month(month_bcd_i, year_bcd_i);
        max_val = MAX_VAL;
        if (DOM_MODE && (dim < MAX_VAL)) begin
            max_val = dim;
        end
    end

    rtc_field_editor_bcd_step u_step (
        .val_i  (value_in_i),
        .dir_i  (dir_q),
        .min_i  (MIN_VAL),
        .max_i  (max_val),
        .next_o (value_d)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            dir_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            a_d_q       <= 1'b0;
            w_r_q       <= 1'b0;
            bus_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            value_out_q <= 8'h00;
        end else begin
            // History always tracks the buttons, so a press swallowed while busy
            // cannot fire later.
            up_q   <= up_i;
            down_q <= down_i;
            if (!enable_i) begin
                state_q    <= ST_IDLE;
                bus_req_q  <= 1'b0;
                a_d_q      <= 1'b0;
                w_r_q      <= 1'b0;
                bus_data_q <= 8'h00;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (up_p ^ down_p) begin
                            state_q <= ST_CALC;
                            dir_q   <= up_p;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_CALC: begin
                        value_out_q <= value_d;
                        state_q     <= ST_ADDR;
                        bus_req_q   <= 1'b1;
                        a_d_q       <= 1'b0;
                        w_r_q       <= 1'b1;
                        bus_data_q  <= FIELD_ADDR;
                    end
                    ST_ADDR: begin
                        if (bus_ack_i) begin
                            state_q    <= ST_DATA;
                            a_d_q      <= 1'b1;
                            bus_data_q <= value_out_q;
                        end
                    end
                    ST_DATA: begin
                        if (bus_ack_i) begin
                            state_q    <= ST_DONE;
                            bus_req_q  <= 1'b0;
                            a_d_q      <= 1'b0;
                            w_r_q      <= 1'b0;
                            bus_data_q <= 8'h00;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        bus_req_q  <= 1'b0;
                        a_d_q      <= 1'b0;
                        w_r_q      <= 1'b0;
                        bus_data_q <= 8'h00;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_req_o   = bus_req_q;
    assign a_d_o       = a_d_q;
    assign w_r_o       = w_r_q;
    assign bus_data_o  = bus_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign value_out_o = value_out_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
// tb/tb_rtc_field_editor.sv - self-checking bench for rtc_field_editor
module tb_rtc_field_editor;
    import rtc_field_editor_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic up = 1'b0;
    logic down = 1'b0;
    logic [7:0] value_in = 8'h00;
    logic [7:0] month = 8'h01;
    logic [7:0] year = 8'h00;
    logic bus_ack = 1'b0;

    logic [1:0] req_w, ad_w, wr_w, busy_w, done_w;
    logic [7:0] data_w [2];
    logic [7:0] vout_w [2];

    always #5 clk = ~clk;

    // Instance 0: day-of-month field; instance 1: minutes-like 00..59 field.
    rtc_field_editor #(.FIELD_ADDR(RTC_ADDR_DAY), .MIN_VAL(8'h01), .MAX_VAL(8'h31), .DOM_MODE(1'b1)) dut_dom (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .up_i(up), .down_i(down),
        .value_in_i(value_in), .month_bcd_i(month), .year_bcd_i(year), .bus_ack_i(bus_ack),
        .bus_req_o(req_w[0]), .a_d_o(ad_w[0]), .w_r_o(wr_w[0]), .bus_data_o(data_w[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .value_out_o(vout_w[0]));

    rtc_field_editor #(.FIELD_ADDR(RTC_ADDR_MIN), .MIN_VAL(8'h00), .MAX_VAL(8'h59), .DOM_MODE(1'b0)) dut_plain (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .up_i(up), .down_i(down),
        .value_in_i(value_in), .month_bcd_i(month), .year_bcd_i(year), .bus_ack_i(bus_ack),
        .bus_req_o(req_w[1]), .a_d_o(ad_w[1]), .w_r_o(wr_w[1]), .bus_data_o(data_w[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .value_out_o(vout_w[1]));

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_STEP = 1, P_ADDR = 2, P_DATA = 3, P_FIN = 4;
    int         cfg_min [2] = '{1, 0};
    int         cfg_max [2] = '{31, 59};
    bit         cfg_dom [2] = '{1'b1, 1'b0};
    logic [7:0] cfg_addr[2] = '{8'h24, 8'h21};

    int         m_ph  [2] = '{0, 0};
    bit         m_dir [2];
    bit         m_req [2], m_ad[2], m_wr[2], m_busy[2], m_done[2];
    logic [7:0] m_data[2] = '{8'h00, 8'h00};
    logic [7:0] m_vout[2] = '{8'h00, 8'h00};
    bit         h_up = 1'b0, h_dn = 1'b0;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int month_days(input logic [7:0] mon, input logic [7:0] yr);
        int m;
        m = bcd2int(mon);
        if (m == 2) return (bcd2int(yr) % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] model_step(input int k, input logic [7:0] val, input bit dir,
                                              input logic [7:0] mon, input logic [7:0] yr);
        int mx, v;
        bit ok;
        mx = cfg_max[k];
        if (cfg_dom[k] && month_days(mon, yr) < mx) mx = month_days(mon, yr);
        v  = bcd2int(val);
        ok = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (v >= cfg_min[k]) && (v <= mx);
        if (dir) return (!ok || v == mx) ? int2bcd(cfg_min[k]) : int2bcd(v + 1);
        return (!ok || v == cfg_min[k]) ? int2bcd(mx) : int2bcd(v - 1);
    endfunction

    always @(posedge clk) begin
        bit pu, pd;
        pu = up && !h_up;
        pd = down && !h_dn;
        for (int k = 0; k < 2; k++) begin
            if (!reset || (m_ph[k] != P_IDLE && !enable)) begin
                m_ph[k] = P_IDLE;
                m_req[k] = 0; m_ad[k] = 0; m_wr[k] = 0; m_data[k] = 8'h00;
                m_busy[k] = 0; m_done[k] = 0;
                if (!reset) begin m_vout[k] = 8'h00; m_dir[k] = 0; end
            end else begin
                case (m_ph[k])
                    P_IDLE: if (enable && (pu ^ pd)) begin
                        m_ph[k] = P_STEP; m_dir[k] = pu; m_busy[k] = 1;
                    end
                    P_STEP: begin
                        m_vout[k] = model_step(k, value_in, m_dir[k], month, year);
                        m_ph[k] = P_ADDR; m_req[k] = 1; m_ad[k] = 0; m_wr[k] = 1; m_data[k] = cfg_addr[k];
                    end
                    P_ADDR: if (bus_ack) begin m_ph[k] = P_DATA; m_ad[k] = 1; m_data[k] = m_vout[k]; end
                    P_DATA: if (bus_ack) begin
                        m_ph[k] = P_FIN; m_req[k] = 0; m_ad[k] = 0; m_wr[k] = 0; m_data[k] = 8'h00;
                        m_busy[k] = 0; m_done[k] = 1;
                    end
                    default: begin m_done[k] = 0; m_ph[k] = P_IDLE; end
                endcase
            end
        end
        h_up = reset ? up : 1'b0;
        h_dn = reset ? down : 1'b0;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;
    bit ack_auto = 1;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] dut_pack(input int k);
        return {req_w[k], ad_w[k], wr_w[k], data_w[k], busy_w[k], done_w[k], vout_w[k]};
    endfunction

    function automatic logic [20:0] model_pack(input int k);
        return {m_req[k], m_ad[k], m_wr[k], m_data[k], m_busy[k], m_done[k], m_vout[k]};
    endfunction

    // Every cycle: compare both DUTs to the model, then drive the bus ack.
    task automatic tick();
        @(negedge clk);
        if (chk_on)
            for (int k = 0; k < 2; k++)
                check($sformatf("cycle%0d_dut%0d", cyc, k), 32'(dut_pack(k)), 32'(model_pack(k)));
        bus_ack = ack_auto ? (req_w[0] && !bus_ack) : 1'b0;
        cyc++;
    endtask

    task automatic run_press(input bit pu, input bit pd, input logic [7:0] v, input logic [7:0] mon,
                             input logic [7:0] yr, output int lat, output logic [7:0] addr,
                             output logic [7:0] data, output int ndone);
        lat = -1; addr = 8'hxx; data = 8'hxx; ndone = 0;
        tick();
        value_in = v; month = mon; year = yr; up = pu; down = pd;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) begin up = 0; down = 0; end
            if (lat < 0 && req_w[0]) lat = c;
            if (bus_ack && req_w[0]) begin
                if (!ad_w[0]) addr = data_w[0];
                else data = data_w[0];
            end
            if (done_w[0]) ndone++;
        end
    endtask

    typedef struct {
        bit pu; bit pd; logic [7:0] v; logic [7:0] mon; logic [7:0] yr;
        logic [7:0] exp_dom; logic [7:0] exp_plain;
    } vec_t;

    vec_t vecs[8] = '{
        '{1, 0, 8'h31, 8'h12, 8'h24, 8'h01, 8'h32},
        '{0, 1, 8'h01, 8'h02, 8'h24, 8'h29, 8'h00},
        '{0, 1, 8'h01, 8'h02, 8'h23, 8'h28, 8'h00},
        '{1, 0, 8'h09, 8'h12, 8'h24, 8'h10, 8'h10},
        '{0, 1, 8'h00, 8'h12, 8'h24, 8'h31, 8'h59},
        '{1, 0, 8'h35, 8'h12, 8'h24, 8'h01, 8'h36},
        '{1, 0, 8'h1A, 8'h04, 8'h24, 8'h01, 8'h00},
        '{1, 0, 8'h30, 8'h04, 8'h24, 8'h01, 8'h31}
    };

    initial begin
        int lat, nd, cnt;
        logic [7:0] a, d;

        for (int i = 0; i < 3; i++) tick();
        chk_on = 1;
        check("reset_dut0", 32'(dut_pack(0)), 32'h0);
        check("reset_dut1", 32'(dut_pack(1)), 32'h0);
        reset = 1;
        tick();

        foreach (vecs[i]) begin
            run_press(vecs[i].pu, vecs[i].pd, vecs[i].v, vecs[i].mon, vecs[i].yr, lat, a, d, nd);
            check($sformatf("vec%0d_dom_value", i), 32'(vout_w[0]), 32'(vecs[i].exp_dom));
            check($sformatf("vec%0d_plain_value", i), 32'(vout_w[1]), 32'(vecs[i].exp_plain));
            check($sformatf("vec%0d_done_count", i), nd, 1);
            check($sformatf("vec%0d_data_phase", i), 32'(d), 32'(vecs[i].exp_dom));
            if (i == 0) begin
                check("vec0_latency", lat, 2);
                check("vec0_addr_phase", 32'(a), 32'h24);
            end
        end

        // Both buttons rise together: no transaction, values untouched.
        tick(); up = 1; down = 1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin tick(); up = 0; down = 0; cnt += busy_w[0] + busy_w[1]; end
        check("both_no_busy", cnt, 0);
        check("both_dom_hold", 32'(vout_w[0]), 32'h01);
        check("both_plain_hold", 32'(vout_w[1]), 32'h31);

        // Up held 20 cycles, down rising mid-transaction: exactly one write.
        tick(); value_in = 8'h58; month = 8'h12; up = 1;
        nd = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 3) down = 1;
            if (c == 20) begin up = 0; down = 0; end
            nd += done_w[0];
        end
        check("held_one_txn", nd, 1);
        check("held_dom_value", 32'(vout_w[0]), 32'h01);
        check("held_plain_value", 32'(vout_w[1]), 32'h59);

        // Ack withheld in ADDR for 10 cycles, then enable drops.
        ack_auto = 0;
        tick(); value_in = 8'h10; up = 1;
        tick(); up = 0;
        tick();
        cnt = 0;
        for (int c = 0; c < 10; c++) begin tick(); cnt += (req_w[0] && !ad_w[0]) ? 1 : 0; end
        check("stall_addr_held", cnt, 10);
        enable = 0;
        tick();
        check("abort_req", 32'(req_w), 32'h0);
        check("abort_busy", 32'(busy_w), 32'h0);
        enable = 1;
        nd = 0;
        for (int c = 0; c < 5; c++) begin tick(); nd += done_w[0] + done_w[1]; end
        check("abort_no_done", nd, 0);

        // Reset while in the data phase.
        tick(); value_in = 8'h20; up = 1;
        tick(); up = 0;
        cnt = 0;
        while (!req_w[0] && cnt < 10) begin tick(); cnt++; end
        check("rst_req_seen", 32'(req_w[0]), 32'h1);
        bus_ack = 1;
        tick();
        check("rst_in_data", 32'(ad_w[0]), 32'h1);
        reset = 0;
        tick();
        check("rst_mid_dut0", 32'(dut_pack(0)), 32'h0);
        check("rst_mid_dut1", 32'(dut_pack(1)), 32'h0);
        reset = 1;
        ack_auto = 1;
        tick();

        run_press(1, 0, 8'h35, 8'h12, 8'h24, lat, a, d, nd);
        check("post_rst_dom_value", 32'(vout_w[0]), 32'h01);
        check("post_rst_done", nd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
